// File: rtl/apb_spi_slave_fifo.sv
// APB-programmable SPI slave with parametrised frame width, TX/RX FIFOs,
// all four CPOL/CPHA modes, sticky error flags and a maskable interrupt.
module apb_spi_slave_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  input  logic        s_sck,
  input  logic        s_ss,
  input  logic        s_mosi,
  output logic        s_miso,
  output logic        s_miso_oe,
  output logic        interrupt,
  output logic        rx_data_ready,
  output logic        tx_reg_empty
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);

  logic [SYNC_STAGES-1:0] r_sck_s;
  logic [SYNC_STAGES-1:0] r_ss_s;
  logic [SYNC_STAGES-1:0] r_mosi_s;
  logic                   r_sck_d;
  logic                   r_ss_d;
  logic [7:0]             r_ctrl;
  logic [2:0]             r_flags;
  logic                   r_irq;
  logic [DW-1:0]          r_tx_mem [FIFO_DEPTH];
  logic [DW-1:0]          r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_tx_wp;
  logic [AW-1:0]          r_tx_rp;
  logic [AW-1:0]          r_rx_wp;
  logic [AW-1:0]          r_rx_rp;
  logic [CW-1:0]          r_tx_cnt;
  logic [CW-1:0]          r_rx_cnt;
  logic [DW-1:0]          r_tx_sr;
  logic [DW-1:0]          r_rx_sr;
  logic [BW-1:0]          r_cnt;
  logic                   r_done;
  logic                   r_miso;

  logic w_en, w_cpol, w_cpha, w_lsb;
  logic [3:0] w_ie;
  logic w_sck, w_ss, w_mosi;
  logic w_wr, w_rd, w_wr_ctrl, w_wr_stat, w_wr_tx, w_rd_rx;
  logic w_flush, w_sck_chg, w_lead, w_trail, w_act;
  logic w_ss_fall, w_ss_rise, w_sample, w_shift, w_load, w_done;
  logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic [DW-1:0] w_tx_word;
  logic [2:0] w_set, w_clr;
  logic [31:0] w_status;
  logic w_unused;

  assign w_en   = r_ctrl[0];
  assign w_cpol = r_ctrl[1];
  assign w_cpha = r_ctrl[2];
  assign w_lsb  = r_ctrl[3];
  assign w_ie   = r_ctrl[7:4];

  assign w_sck  = r_sck_s[SYNC_STAGES-1];
  assign w_ss   = r_ss_s[SYNC_STAGES-1];
  assign w_mosi = r_mosi_s[SYNC_STAGES-1];

  assign w_wr      = PSEL & PENABLE & PWRITE;
  assign w_rd      = PSEL & PENABLE & ~PWRITE;
  assign w_wr_ctrl = w_wr & (PADDR[3:2] == 2'd0);
  assign w_wr_stat = w_wr & (PADDR[3:2] == 2'd1);
  assign w_wr_tx   = w_wr & (PADDR[3:2] == 2'd2);
  assign w_rd_rx   = w_rd & (PADDR[3:2] == 2'd3);
  assign w_flush   = w_wr_ctrl & w_en & ~PWDATA[0];

  assign w_sck_chg = w_sck ^ r_sck_d;
  assign w_lead    = w_sck_chg & (r_sck_d == w_cpol);
  assign w_trail   = w_sck_chg & (w_sck == w_cpol);
  assign w_act     = w_en & ~w_ss;
  assign w_ss_fall = w_en & r_ss_d & ~w_ss;
  assign w_ss_rise = w_en & ~r_ss_d & w_ss;
  assign w_sample  = w_act & ~r_done & (w_cpha ? w_trail : w_lead);
  // CPHA=0: the trailing edge closing a word must not shift the new word
  assign w_shift   = w_act & (w_cpha ? w_lead : (w_trail & (r_cnt != '0)));
  assign w_done    = r_done & ~w_flush;
  assign w_load    = ~w_flush & (w_ss_fall | (r_done & w_act));

  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == CW'(FIFO_DEPTH));
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == CW'(FIFO_DEPTH));
  assign w_tx_push  = w_wr_tx & ~w_tx_full;
  assign w_tx_pop   = w_load & ~w_tx_empty;
  assign w_rx_push  = w_done & ~w_rx_full;
  assign w_rx_pop   = w_rd_rx & ~w_rx_empty;
  assign w_tx_word  = w_tx_empty ? '0 : r_tx_mem[r_tx_rp];

  assign w_set = {w_wr_tx & w_tx_full, w_load & w_tx_empty, w_done & w_rx_full};
  assign w_clr = w_wr_stat ? PWDATA[6:4] : 3'b000;

  assign w_unused = ^{PADDR[1:0], PWDATA};

  function automatic logic [DW-1:0] f_shl(input logic [DW-1:0] w,
                                          input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic f_first(input logic [DW-1:0] w,
                                   input logic lsb);
    return lsb ? w[0] : w[DW-1];
  endfunction

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_sck_s  <= '0;
      r_ss_s   <= '0;
      r_mosi_s <= '0;
      r_sck_d  <= 1'b0;
      r_ss_d   <= 1'b0;
    end else begin
      r_sck_s  <= {r_sck_s[SYNC_STAGES-2:0], s_sck};
      r_ss_s   <= {r_ss_s[SYNC_STAGES-2:0], s_ss};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], s_mosi};
      r_sck_d  <= w_sck;
      r_ss_d   <= w_ss;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_ctrl  <= '0;
      r_flags <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= PWDATA[7:0];
      r_flags <= (r_flags & ~w_clr) | w_set;
      r_irq   <= |(w_ie & {r_flags[1], r_flags[0], w_tx_empty, ~w_rx_empty});
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_tx_mem[i] <= '0;
    end else if (w_flush) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_mem[r_tx_wp] <= PWDATA[DW-1:0];
        r_tx_wp <= r_tx_wp + AW'(1);
      end
      if (w_tx_pop) r_tx_rp <= r_tx_rp + AW'(1);
      r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_rx_mem[i] <= '0;
    end else if (w_flush) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_mem[r_rx_wp] <= r_rx_sr;
        r_rx_wp <= r_rx_wp + AW'(1);
      end
      if (w_rx_pop) r_rx_rp <= r_rx_rp + AW'(1);
      r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_tx_sr <= '0;
      r_rx_sr <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_miso  <= 1'b0;
    end else if (w_flush) begin
      r_tx_sr <= '0;
      r_rx_sr <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_miso  <= 1'b0;
    end else if (w_load) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
      if (w_cpha) begin
        r_tx_sr <= w_tx_word;
      end else begin
        r_tx_sr <= f_shl(w_tx_word, w_lsb);
        r_miso  <= f_first(w_tx_word, w_lsb);
      end
    end else if (w_ss_rise | r_done) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_sample) begin
        r_rx_sr <= w_lsb ? {w_mosi, r_rx_sr[DW-1:1]}
                         : {r_rx_sr[DW-2:0], w_mosi};
        r_cnt   <= r_cnt + BW'(1);
        if (r_cnt == BW'(DW - 1)) r_done <= 1'b1;
      end
      if (w_shift) begin
        r_miso  <= f_first(r_tx_sr, w_lsb);
        r_tx_sr <= f_shl(r_tx_sr, w_lsb);
      end
    end
  end

  always_comb begin
    w_status = '0;
    w_status[0] = ~w_rx_empty;
    w_status[1] = w_rx_full;
    w_status[2] = w_tx_empty;
    w_status[3] = w_tx_full;
    w_status[6:4] = r_flags;
    w_status[8 +: CW] = r_rx_cnt;
    w_status[12 +: CW] = r_tx_cnt;
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      case (PADDR[3:2])
        2'd0: PRDATA[7:0] = r_ctrl;
        2'd1: PRDATA = w_status;
        2'd2: PRDATA = '0;
        2'd3: if (!w_rx_empty) PRDATA[DW-1:0] = r_rx_mem[r_rx_rp];
        default: PRDATA = '0;
      endcase
    end
  end

  assign s_miso        = r_miso;
  assign s_miso_oe     = w_en & ~w_ss;
  assign interrupt     = r_irq;
  assign rx_data_ready = ~w_rx_empty;
  assign tx_reg_empty  = w_tx_empty;

endmodule

// File: tb/tb_apb_spi_slave_fifo.sv
// Directed plus randomized bench for apb_spi_slave_fifo against a
// queue-based transaction model with an SPI master driver.
module tb_apb_spi_slave_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int HALF = 8;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [3:0]  PADDR = 4'h0;
  logic [31:0] PWDATA = 32'h0;
  logic [31:0] PRDATA;
  logic        s_sck = 1'b0;
  logic        s_ss = 1'b1;
  logic        s_mosi = 1'b0;
  logic        s_miso;
  logic        s_miso_oe;
  logic        interrupt;
  logic        rx_data_ready;
  logic        tx_reg_empty;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] txq[$];
  logic [DW-1:0] rxq[$];
  logic m_rxovf = 1'b0;
  logic m_txunf = 1'b0;
  logic m_txovf = 1'b0;
  logic [7:0] m_ctrl = 8'h00;

  apb_spi_slave_fifo #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)
  ) u_dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .s_sck(s_sck), .s_ss(s_ss), .s_mosi(s_mosi), .s_miso(s_miso),
    .s_miso_oe(s_miso_oe), .interrupt(interrupt),
    .rx_data_ready(rx_data_ready), .tx_reg_empty(tx_reg_empty)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0] = (rxq.size() != 0);
    s[1] = (rxq.size() == DEPTH);
    s[2] = (txq.size() == 0);
    s[3] = (txq.size() == DEPTH);
    s[4] = m_rxovf;
    s[5] = m_txunf;
    s[6] = m_txovf;
    s[11:8] = 4'(rxq.size());
    s[15:12] = 4'(txq.size());
    return s;
  endfunction

  function automatic logic m_irq();
    logic [3:0] src;
    src = {m_txunf, m_rxovf, txq.size() == 0, rxq.size() != 0};
    return |(src & m_ctrl[7:4]);
  endfunction

  function automatic logic [DW-1:0] m_pop_tx();
    if (txq.size() == 0) begin
      m_txunf = 1'b1;
      return '0;
    end
    return txq.pop_front();
  endfunction

  task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic m_wr_ctrl(input logic [7:0] d);
    apb_wr(4'h0, {24'h0, d});
    if (m_ctrl[0] && !d[0]) begin
      txq.delete();
      rxq.delete();
    end
    m_ctrl = d;
    s_sck = d[1];
    wait_n(4);
  endtask

  task automatic m_wr_tx(input logic [DW-1:0] d);
    apb_wr(4'h8, {24'h0, d});
    if (txq.size() == DEPTH) m_txovf = 1'b1;
    else txq.push_back(d);
  endtask

  task automatic m_wr_status(input logic [31:0] d);
    apb_wr(4'h4, d);
    if (d[4]) m_rxovf = 1'b0;
    if (d[5]) m_txunf = 1'b0;
    if (d[6]) m_txovf = 1'b0;
  endtask

  task automatic m_rd_rx(input string tag);
    logic [31:0] d;
    logic [DW-1:0] e;
    apb_rd(4'hC, d);
    e = (rxq.size() == 0) ? '0 : rxq.pop_front();
    chk(tag, d, {24'h0, e});
  endtask

  task automatic m_chk_status(input string tag);
    logic [31:0] d;
    apb_rd(4'h4, d);
    chk(tag, d, m_status());
  endtask

  task automatic m_chk_irq(input string tag);
    wait_n(2);
    chk(tag, {31'h0, interrupt}, {31'h0, m_irq()});
  endtask

  task automatic spi_frame(input logic [DW-1:0] mo, input int nbits,
                           output logic [DW-1:0] mi);
    logic cpol, cpha, lsb;
    int b;
    cpol = m_ctrl[1]; cpha = m_ctrl[2]; lsb = m_ctrl[3];
    mi = '0;
    s_sck = cpol;
    s_ss = 1'b0;
    if (cpha) wait_n(HALF);
    for (int i = 0; i < nbits; i++) begin
      b = lsb ? i : DW - 1 - i;
      if (!cpha) begin
        s_mosi = mo[b];
        wait_n(HALF);
        s_sck = ~cpol;
        mi[b] = s_miso;
        wait_n(HALF);
        s_sck = cpol;
      end else begin
        s_sck = ~cpol;
        s_mosi = mo[b];
        wait_n(HALF);
        s_sck = cpol;
        mi[b] = s_miso;
        wait_n(HALF);
      end
    end
    wait_n(HALF);
    s_ss = 1'b1;
    wait_n(2 * HALF);
  endtask

  task automatic m_frame(input logic [DW-1:0] mo, input string tag,
                         output logic [DW-1:0] mi);
    logic [DW-1:0] e;
    logic [DW-1:0] lost;
    e = m_pop_tx();
    spi_frame(mo, DW, mi);
    chk(tag, {24'h0, mi}, {24'h0, e});
    if (rxq.size() == DEPTH) m_rxovf = 1'b1;
    else rxq.push_back(mo);
    lost = m_pop_tx();
  endtask

  initial begin
    logic [DW-1:0] mi;
    logic [31:0] d;
    int n;

    #1;
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_miso", {31'h0, s_miso}, 32'h0);
    chk("rst_oe", {31'h0, s_miso_oe}, 32'h0);
    chk("rst_irq", {31'h0, interrupt}, 32'h0);
    chk("rst_rxrdy", {31'h0, rx_data_ready}, 32'h0);
    chk("rst_txe", {31'h0, tx_reg_empty}, 32'h1);
    wait_n(3);
    PRESETN = 1'b1;
    wait_n(4);
    apb_rd(4'h4, d);
    chk("rst_status", d, 32'h0000_0004);

    // mode 0 basic exchange
    m_wr_ctrl(8'h01);
    m_wr_tx(8'hA5);
    m_frame(8'h3C, "m0_miso", mi);
    chk("m0_rxrdy_hi", {31'h0, rx_data_ready}, 32'h1);
    m_rd_rx("m0_rxdata");
    chk("m0_rxrdy_lo", {31'h0, rx_data_ready}, 32'h0);
    m_chk_status("m0_status");
    m_wr_status(32'h70);

    // all modes, both bit orders
    for (int m = 0; m < 8; m++) begin
      logic [7:0] c;
      c = {4'h0, 1'(m >> 2), 1'(m >> 1), 1'(m), 1'b1};
      m_wr_ctrl(c);
      m_wr_tx(c[3] ? 8'h01 : 8'($urandom));
      m_frame(8'h81, "modes_miso", mi);
      if (c[3]) chk("lsb_first_bit", {31'h0, mi[0]}, 32'h1);
      m_rd_rx("modes_rx");
    end
    m_chk_status("modes_status");

    // RX overflow
    m_wr_ctrl(8'h01);
    m_wr_status(32'h70);
    for (int k = 0; k < 5; k++) m_frame(8'(8'h10 + k), "ovf_miso", mi);
    m_chk_status("ovf_status");
    for (int k = 0; k < 4; k++) m_rd_rx("ovf_rx");
    m_wr_status(32'h10);
    m_chk_status("ovf_clr_status");

    // TX underrun raises interrupt
    m_wr_status(32'h70);
    m_wr_ctrl(8'h81);
    m_chk_irq("unf_irq_lo");
    m_frame(8'h77, "unf_miso", mi);
    m_chk_status("unf_status");
    m_chk_irq("unf_irq_hi");
    m_rd_rx("unf_rx");

    // TX overflow, then EN 1->0 flush keeps sticky flags
    m_wr_ctrl(8'h01);
    m_wr_status(32'h70);
    for (int k = 0; k < 5; k++) m_wr_tx(8'(8'hC0 + k));
    m_chk_status("txovf_status");
    m_wr_ctrl(8'h00);
    m_chk_status("flush_status");
    chk("flush_txe", {31'h0, tx_reg_empty}, 32'h1);

    // aborted frame, then full frame
    m_wr_ctrl(8'h01);
    m_wr_status(32'h70);
    mi = m_pop_tx();
    spi_frame(8'hFF, 3, mi);
    m_frame(8'h5A, "abort_miso", mi);
    m_chk_status("abort_status");
    m_rd_rx("abort_rx");

    // randomized traffic
    for (int it = 0; it < 14; it++) begin
      logic [7:0] c;
      c = {4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
           1'($urandom), 1'b1};
      m_wr_ctrl(c);
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) m_wr_tx(8'($urandom));
      n = $urandom_range(1, 2);
      for (int k = 0; k < n; k++) m_frame(8'($urandom), "rnd_miso", mi);
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) m_rd_rx("rnd_rx");
      m_chk_status("rnd_status");
      m_chk_irq("rnd_irq");
      if ($urandom_range(0, 3) == 0) m_wr_status(32'h70);
    end

    // reset asserted mid-frame
    while (rxq.size() != 0) m_rd_rx("drain_rx");
    m_wr_ctrl(8'h21);
    m_wr_tx(8'hFF);
    m_wr_tx(8'hFF);
    m_frame(8'h33, "pre_rst_frame", mi);
    m_wr_tx(8'hFF);
    s_ss = 1'b0;
    wait_n(HALF);
    s_sck = 1'b1;
    wait_n(HALF);
    chk("pre_rst_miso", {31'h0, s_miso}, 32'h1);
    chk("pre_rst_oe", {31'h0, s_miso_oe}, 32'h1);
    chk("pre_rst_irq", {31'h0, interrupt}, 32'h1);
    chk("pre_rst_rxrdy", {31'h0, rx_data_ready}, 32'h1);
    #2 PRESETN = 1'b0;
    #1;
    chk("mid_rst_prdata", PRDATA, 32'h0);
    chk("mid_rst_miso", {31'h0, s_miso}, 32'h0);
    chk("mid_rst_oe", {31'h0, s_miso_oe}, 32'h0);
    chk("mid_rst_irq", {31'h0, interrupt}, 32'h0);
    chk("mid_rst_rxrdy", {31'h0, rx_data_ready}, 32'h0);
    chk("mid_rst_txe", {31'h0, tx_reg_empty}, 32'h1);
    s_ss = 1'b1;
    s_sck = 1'b0;
    txq.delete();
    rxq.delete();
    m_rxovf = 1'b0;
    m_txunf = 1'b0;
    m_txovf = 1'b0;
    m_ctrl = 8'h00;
    wait_n(2);
    PRESETN = 1'b1;
    wait_n(6);
    apb_rd(4'h4, d);
    chk("post_rst_status", d, 32'h0000_0004);
    m_chk_status("post_rst_model");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_spi_slave_fifo.md
Name: apb_spi_slave_fifo

Overview:
Parametrised APB SPI slave replacing the fixed 8-bit slave-only core instance. Adds configurable frame width, TX/RX FIFOs, all four CPOL/CPHA modes, sticky error flags and maskable interrupts. Sits on the peripheral APB bus. s_sck/s_ss/s_mosi are oversampled in the PCLK domain, so s_sck must not exceed PCLK/8.

Parameters:
DATA_WIDTH, 8, SPI frame width in bits; legal range 4..32.
FIFO_DEPTH, 4, entries per TX and RX FIFO; power of 2, at least 2.
SYNC_STAGES, 2, synchroniser flops on s_sck, s_ss and s_mosi; at least 2.

Ports:
PCLK  in  1  system clock; all logic on the rising edge.
PRESETN  in  1  asynchronous active-low reset.
PSEL  in  1  APB select.
PENABLE  in  1  APB enable phase.
PWRITE  in  1  APB write.
PADDR  in  4  byte address; word-aligned registers at 0x0, 0x4, 0x8, 0xC.
PWDATA  in  32  APB write data.
PRDATA  out  32  APB read data; combinational from PADDR; unused bits read 0.
s_sck  in  1  SPI clock from the external master.
s_ss  in  1  SPI slave select, active low.
s_mosi  in  1  SPI data in.
s_miso  out  1  SPI data out.
s_miso_oe  out  1  output enable for the s_miso pad.
interrupt  out  1  level interrupt.
rx_data_ready  out  1  RX FIFO not empty.
tx_reg_empty  out  1  TX FIFO empty.

Behaviour:
- Reset values:
  - PRDATA=0, s_miso=0, s_miso_oe=0, interrupt=0, rx_data_ready=0, tx_reg_empty=1.
  - All registers 0; both FIFOs empty; bit counter 0.
- APB: zero wait states. A write occurs when PSEL & PENABLE & PWRITE. A read has side effects only when PSEL & PENABLE & !PWRITE.
- 0x0 CTRL (RW):
  - bit0 EN, bit1 CPOL, bit2 CPHA, bit3 LSB_FIRST.
  - bits[7:4] IE for RXNE, TXE, RXOVF, TXUNF.
  - Writing EN 1->0 flushes both FIFOs and resets the shift logic. Other CTRL fields and STATUS are kept.
- 0x4 STATUS:
  - bit0 RXNE, bit1 RXFULL, bit2 TXE, bit3 TXFULL: read-only.
  - bit4 RXOVF, bit5 TXUNF, bit6 TXOVF: sticky, write-1-to-clear.
  - Bits[11:8] hold RX count and bits[15:12] hold TX count, as wide as needed.
- 0x8 TXDATA (WO): a write pushes PWDATA[DATA_WIDTH-1:0]. If the TX FIFO is full, data is dropped and TXOVF is set.
- 0xC RXDATA (RO): a read returns the head and pops it. If the RX FIFO is empty, it returns 0, does not pop, and sets no flag.
- Input path:
  - s_sck, s_ss and s_mosi pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised s_sck with one extra register.
  - Leading edge = transition away from the CPOL idle level; trailing edge = return to it.
- Frame, with EN=1 and synchronised ss low:
  - On ss falling: the shift-out register loads the TX FIFO head and pops it. If the FIFO is empty, it loads 0 and sets TXUNF. Bit counter clears.
  - CPHA=0: s_miso presents bit 0 at load. Sample s_mosi on leading edges; shift s_miso on trailing edges.
  - CPHA=1: shift on leading edges (the first leading edge presents bit 0); sample on trailing edges.
  - Bit order: MSB first unless LSB_FIRST=1.
  - After the DATA_WIDTH-th sample, the assembled word is pushed to the RX FIFO on the next PCLK. If the RX FIFO is full, the word is dropped and RXOVF is set.
  - In the same cycle, the bit counter wraps to 0 and the next TX word loads, with the same underrun rule.
- ss rising mid-frame: the partial RX word is discarded and the counter resets. The partially sent TX word is lost and is not re-queued.
- EN=0: edges and ss are ignored; s_miso_oe=0.
- s_miso_oe = EN & ~ss_sync.
- Simultaneous events:
  - An APB push and a frame-load pop in the same cycle on the TX FIFO are both honoured; the count is unchanged.
  - An APB pop and a shift-in push in the same cycle on the RX FIFO are both honoured.
  - A W1C and a set of the same sticky bit in the same cycle: set wins.
- Outputs:
  - rx_data_ready = RXNE; tx_reg_empty = TXE.
  - interrupt is registered and equals OR(STATUS[0,2,4,5] & IE).

Test Plan:
- Reset: PRESETN low mid-frame -> all outputs at reset values immediately; after release STATUS=0x0004, RX count 0.
- Mode 0, DATA_WIDTH=8: CTRL=0x01, write TXDATA=0xA5; master sends 0x3C -> s_miso shows 1,0,1,0,0,1,0,1; RXDATA reads 0x3C; rx_data_ready falls after the read.
- Modes 1-3, plus LSB_FIRST=1: master sends 0x81 -> RXDATA=0x81 in all modes; TX 0x01 with LSB_FIRST appears on s_miso as bit 1 first.
- RX overflow: FIFO_DEPTH=4, five frames with no reads -> STATUS.RXOVF=1 and RXDATA returns the first four words in order; write 0x10 to STATUS -> RXOVF=0.
- TX underrun and interrupt: CTRL IE bit TXUNF set, frame with TX FIFO empty -> s_miso all 0s, TXUNF=1, interrupt=1 one cycle later.
- ss aborted after 3 bits, then a full frame 0x5A -> only 0x5A appears in the RX FIFO; count=1.
